// File: rtl/avariya_monitor.sv
// avariya_monitor: synchronises, debounces and latches N fault lines and gates the
// registered power permit behind a power-up hold-off FSM.
module avariya_monitor #(
  parameter int N_CH       = 4,
  parameter int CW         = 16,
  parameter int DEB_CYCLES = 1000,
  parameter int HW         = 24,
  parameter int HOLDOFF    = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] fault_raw,
  input  logic            clr,
  output logic            avariya,
  output logic [N_CH-1:0] fault_status,
  output logic [7:0]      fault_cnt,
  output logic [1:0]      state
);
  typedef enum logic [1:0] {STARTUP = 2'd0, OK = 2'd1, FAULT = 2'd2} state_t;
  logic [N_CH-1:0]         sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d, latch_q, latch_d;
  logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [7:0]              fcnt_q, fcnt_d;
  logic [HW-1:0]           hcnt_q, hcnt_d;
  state_t                  state_q, state_d;
  logic                    avariya_q, avariya_d;
  always_comb begin
    sync1_d = fault_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (sync2_q[i] == deb_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else cnt_d[i] = cnt_q[i] + 1'b1;
    end
    // set dominates clear, so a channel still in fault cannot be cleared
    latch_d = deb_q | (latch_q & {N_CH{~clr}});
    fcnt_d  = (|(deb_q & ~latch_q) && fcnt_q != 8'hff) ? fcnt_q + 8'd1 : fcnt_q;
    state_d = state_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      STARTUP:
        if (|latch_q) begin
          state_d = FAULT;
          hcnt_d  = '0;
        end else if (hcnt_q == HW'(HOLDOFF - 1)) begin
          state_d = OK;
          hcnt_d  = '0;
        end else hcnt_d = hcnt_q + 1'b1;
      OK:      state_d = |latch_q ? FAULT : OK;
      FAULT:
        if (~|latch_q) begin
          state_d = STARTUP;
          hcnt_d  = '0;
        end
      default: state_d = STARTUP;
    endcase
    avariya_d = (state_d == OK);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      cnt_q     <= '0;
      latch_q   <= '0;
      fcnt_q    <= '0;
      hcnt_q    <= '0;
      state_q   <= STARTUP;
      avariya_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      latch_q   <= latch_d;
      fcnt_q    <= fcnt_d;
      hcnt_q    <= hcnt_d;
      state_q   <= state_d;
      avariya_q <= avariya_d;
    end
  end
  assign avariya      = avariya_q;
  assign fault_status = latch_q;
  assign fault_cnt    = fcnt_q;
  assign state        = state_q;
endmodule
